fp_addsub_seq: RTL and testbench

Parametrised multi-cycle floating-point add/subtract unit. It is a single block with its own controller FSM and datapath. Format per operand is {sign, EXP_W exponent, MAN_W fraction}, with a hidden leading 1 whenever exponent != 0. It sits between an operand source using a valid/ready handshake and a result sink using a valid/ready handshake. Alignment and normalisation shift one bit per cycle, with an early-out path for large exponent gaps.

---
 rtl/fp_addsub_seq.sv | 198 +++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with one-bit-per-cycle alignment and normalisation.
// Truncating, no denormals; the result is held in OUT until the sink accepts it.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ovf,
  output logic                 unf
);
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_CARRY, S_NORM, S_OUT} state_t;

  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [31:0]      EARLY_GAP = 32'(MAN_W + 1);

  state_t               state_q;
  logic                 sa_q, sb_q, sign_q;
  logic [EXP_W-1:0]     ea_q, eb_q, exp_q;
  logic [MAN_W:0]       ma_q, mb_q;
  logic [MAN_W+1:0]     sum_q;
  logic [EXP_W+MAN_W:0] result_q;
  logic                 ovf_q, unf_q, in_ready_q, out_valid_q;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  logic             b_sign_eff, a_special, b_special;

  assign a_exp      = a[MAN_W +: EXP_W];
  assign b_exp      = b[MAN_W +: EXP_W];
  assign a_man      = (a_exp == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
  assign b_man      = (b_exp == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
  assign b_sign_eff = b[EXP_W+MAN_W] ^ op_sub;
  assign a_special  = (a_exp == EXP_ONES);
  assign b_special  = (b_exp == EXP_ONES);

  logic             a_bigger_exp;
  logic [EXP_W-1:0] gap;
  logic [31:0]      gap_w;

  assign a_bigger_exp = ea_q > eb_q;
  assign gap          = a_bigger_exp ? (ea_q - eb_q) : (eb_q - ea_q);
  assign gap_w        = 32'(gap);

  // Signed-magnitude add of the aligned mantissas; exact cancellation yields +0.
  logic [MAN_W+1:0] ma_ext, mb_ext, sum_d;
  logic             sign_d;
  logic [EXP_W-1:0] exp_inc_d;

  assign ma_ext    = {1'b0, ma_q};
  assign mb_ext    = {1'b0, mb_q};
  assign exp_inc_d = exp_q + EXP_ONE;

  always_comb begin
    sum_d  = ma_ext + mb_ext;
    sign_d = sa_q;
    if (sa_q != sb_q) begin
      if (ma_q == mb_q) begin
        sum_d  = '0;
        sign_d = 1'b0;
      end else if (ma_q > mb_q) begin
        sum_d  = ma_ext - mb_ext;
        sign_d = sa_q;
      end else begin
        sum_d  = mb_ext - ma_ext;
        sign_d = sb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      exp_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sa_q       <= a[EXP_W+MAN_W];
            sb_q       <= b_sign_eff;
            ea_q       <= a_exp;
            eb_q       <= b_exp;
            ma_q       <= a_man;
            mb_q       <= b_man;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            if (a_special || b_special) begin
              result_q    <= {(a_special ? a[EXP_W+MAN_W] : b_sign_eff), EXP_ONES, {MAN_W{1'b0}}};
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              state_q <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          if (ea_q == eb_q) begin
            state_q <= S_ADD;
          end else if (gap_w > EARLY_GAP) begin
            // Smaller operand would shift out entirely: drop it in one step.
            if (a_bigger_exp) begin
              mb_q <= '0;
              eb_q <= ea_q;
            end else begin
              ma_q <= '0;
              ea_q <= eb_q;
            end
          end else if (a_bigger_exp) begin
            mb_q <= mb_q >> 1;
            eb_q <= eb_q + EXP_ONE;
          end else begin
            ma_q <= ma_q >> 1;
            ea_q <= ea_q + EXP_ONE;
          end
        end
        S_ADD: begin
          sum_q   <= sum_d;
          sign_q  <= sign_d;
          exp_q   <= ea_q;
          state_q <= sum_d[MAN_W+1] ? S_CARRY : S_NORM;
        end
        S_CARRY: begin
          sum_q <= sum_q >> 1;
          exp_q <= exp_inc_d;
          if (exp_inc_d == EXP_ONES) begin
            result_q    <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (sum_q == '0) begin
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (sum_q[MAN_W]) begin
            result_q    <= {sign_q, exp_q, sum_q[MAN_W-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (exp_q == EXP_ONE) begin
            result_q    <= '0;
            unf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            sum_q <= sum_q << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (single-precision defaults): an arithmetic reference model
// predicts result, flags and latency; a negedge process checks every cycle out_valid is high.
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready, ovf, unf;
  logic [31:0] a, b, result;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic [15:0] lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] xa;
    logic [31:0] xb;
    logic        sub;
    logic [7:0]  hold;
  } vec_t;

  exp_t expq[$];

  fp_addsub_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: align by full shift (truncating), signed-magnitude add, then normalise.
  // Latency counts clock edges after the accept edge until out_valid is seen high.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    exp_t   r;
    int     ea, eb, e, d, align;
    longint ma, mb, s;
    logic   sa, sb, sg;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    sa = x[31];
    sb = y[31] ^ sub;
    ma = 0;
    mb = 0;
    if (ea != 0) ma = 64'h800000 + longint'(x[22:0]);
    if (eb != 0) mb = 64'h800000 + longint'(y[22:0]);
    r = '0;
    if (ea == 255 || eb == 255) begin
      r.res = {((ea == 255) ? sa : sb), 8'hFF, 23'h0};
      r.ovf = 1'b1;
      return r;
    end
    d     = (ea > eb) ? (ea - eb) : (eb - ea);
    align = (d > 24) ? 2 : d + 1;
    if (ea >= eb) begin
      mb = (d > 24) ? 0 : (mb >> d);
      e  = ea;
    end else begin
      ma = (d > 24) ? 0 : (ma >> d);
      e  = eb;
    end
    r.lat = 16'(align + 1);
    if (sa == sb) begin
      s = ma + mb; sg = sa;
    end else if (ma == mb) begin
      s = 0; sg = 1'b0;
    end else if (ma > mb) begin
      s = ma - mb; sg = sa;
    end else begin
      s = mb - ma; sg = sb;
    end
    if (s >= 64'h1000000) begin
      s = s >> 1;
      e = e + 1;
      r.lat = r.lat + 16'd1;
      if (e == 255) begin
        r.res = {sg, 8'hFF, 23'h0};
        r.ovf = 1'b1;
        return r;
      end
    end
    r.lat = r.lat + 16'd1;
    while (1) begin
      if (s == 0) begin
        r.res = '0;
        break;
      end
      if (s[23]) begin
        r.res = {sg, 8'(e), 23'(s)};
        break;
      end
      if (e == 1) begin
        r.res = '0;
        r.unf = 1'b1;
        break;
      end
      s = s << 1;
      e = e - 1;
      r.lat = r.lat + 16'd1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("result", 64'(result), 64'(expq[0].res));
        check("ovf", 64'(ovf), 64'(expq[0].ovf));
        check("unf", 64'(unf), 64'(expq[0].unf));
        check("in_ready_in_out", 64'(in_ready), 64'd0);
        if (out_ready) begin
          $display("txn result=%h ovf=%0d unf=%0d", result, ovf, unf);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic sub, input int hold);
    exp_t e;
    int   n;
    e = model(xa, xb, sub);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    $display("op a=%h b=%h sub=%0d hold=%0d -> expect %h ovf=%0d unf=%0d lat=%0d",
             xa, xb, sub, hold, e.res, e.ovf, e.unf, e.lat);
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    op_sub    = sub;
    out_ready = (hold == 0);
    expq.push_back(e);
    @(posedge clk); #1;
    // Operands only matter on the accept edge.
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op_sub   = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    check("latency", 64'(n), 64'(e.lat));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("held_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("released_out_valid", 64'(out_valid), 64'd0);
    check("in_ready_after_out", 64'(in_ready), 64'd1);
  endtask

  vec_t vecs[] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 8'd0},  // 1.0 + 1.0
    '{32'h3FC00000, 32'h3FC00000, 1'b1, 8'd0},  // 1.5 - 1.5
    '{32'h3F800000, 32'h3F400000, 1'b1, 8'd0},  // 1.0 - 0.75
    '{32'h3F800000, 32'h30800000, 1'b0, 8'd0},  // early-out, gap 30
    '{32'h3F800000, 32'h33800000, 1'b0, 8'd0},  // gap 24, shifted fully
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 8'd0},  // overflow through carry
    '{32'h7F800000, 32'h3F800000, 1'b0, 8'd0},  // special A
    '{32'h3F800000, 32'h7F800000, 1'b1, 8'd0},  // special B, sign flipped
    '{32'h00800000, 32'h00C00000, 1'b1, 8'd0},  // underflow
    '{32'hBF800000, 32'h40000000, 1'b0, 8'd0},  // -1 + 2
    '{32'h00000000, 32'h3F800000, 1'b0, 8'd0},  // 0 + 1
    '{32'h40490FDB, 32'hBF800001, 1'b1, 8'd0},  // truncation path
    '{32'h3F800000, 32'h3F800000, 1'b0, 8'd5}   // sink stalls 5 cycles
  };

  initial begin
    exp_t m;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    m = model(32'h3F800000, 32'h3F800000, 1'b0);
    check("model_1p1_res", 64'(m.res), 64'h40000000);
    check("model_1p1_lat", 64'(m.lat), 64'd4);
    m = model(32'h3F800000, 32'h3F400000, 1'b1);
    check("model_1m075_res", 64'(m.res), 64'h3E800000);
    m = model(32'h3F800000, 32'h30800000, 1'b0);
    check("model_early_res", 64'(m.res), 64'h3F800000);
    m = model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    check("model_ovf", 64'({m.res, m.ovf}), 64'({32'h7F800000, 1'b1}));
    m = model(32'h00800000, 32'h00C00000, 1'b1);
    check("model_unf", 64'({m.res, m.unf}), 64'({32'h00000000, 1'b1}));

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({ovf, unf}), 64'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) do_op(vecs[i].xa, vecs[i].xb, vecs[i].sub, int'(vecs[i].hold));

    // Reset asserted while the unit is partway through a long alignment.
    in_valid = 1'b1;
    a        = 32'h3F800000;
    b        = 32'h33800000;
    op_sub   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_result", 64'(result), 64'h40000000);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_flags", 64'({ovf, unf}), 64'd0);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    do_op(32'h3F800000, 32'h3F400000, 1'b1, 0);
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
